// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 2-bit ALU between two requesters. Each requester
// presents (a, b, sel) with a valid/ready handshake. The arbiter grants one
// requester at a time, captures its operation, runs it through the ALU, and
// returns the 4-bit result with the requester ID on one shared response
// channel. Only one operation is in flight at any time.
//
// Sequence per operation: IDLE (accept) -> EXEC (ALU result registered)
// -> RESP (held until rsp_ready).
//
// Ties in IDLE go to the requester that did not own the last completed
// response, so two continuously valid requesters alternate strictly.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      synchronous, active-high reset
//   req_valid_<n>            requester n has an operation pending
//   req_a_<n>, req_b_<n>     requester n operands (2 bits each)
//   req_sel_<n>              requester n opcode:
//                              0 NOT A, 1 NAND(A,B), 2 A+B, 3 A*B
//   req_ready_<n>            requester n accepted this cycle (combinational)
//   rsp_valid                response held on rsp_id / rsp_y
//   rsp_id                   requester that owns the response
//   rsp_y                    4-bit ALU result, zero-extended
//   rsp_ready                consumer accepts the response
//
// Optional feature (define ALU_ARB_STATS_EN):
//   stat_cnt_0, stat_cnt_1   8-bit wrapping counts of completed responses
//                            per requester, cleared by rst
// -----------------------------------------------------------------------------
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_0,
  input  logic [1:0] req_a_0,
  input  logic [1:0] req_b_0,
  input  logic [1:0] req_sel_0,
  output logic       req_ready_0,
  input  logic       req_valid_1,
  input  logic [1:0] req_a_1,
  input  logic [1:0] req_b_1,
  input  logic [1:0] req_sel_1,
  output logic       req_ready_1,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_y,
  input  logic       rsp_ready
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0] stat_cnt_0,
  output logic [7:0] stat_cnt_1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // Owner of the last completed response; resets to 1 so requester 0 wins
  // the first tie.
  logic       last;

  logic [1:0] cap_a;
  logic [1:0] cap_b;
  logic [1:0] cap_sel;
  logic       cap_id;

  logic       grant_0;
  logic       grant_1;
  logic       rsp_hs;
  logic [3:0] alu_y;

  // ---------------------------------------------------------------------------
  // The shared ALU: purely combinational, result always 4 bits with unused
  // upper bits zero. Widest result is 3*3 = 9, so nothing overflows.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] alu(input logic [1:0] a,
                                     input logic [1:0] b,
                                     input logic [1:0] sel);
    logic [3:0] y;
    case (sel)
      2'd0:    y = {2'b00, ~a};
      2'd1:    y = {2'b00, ~(a & b)};
      2'd2:    y = {1'b0, {1'b0, a} + {1'b0, b}};
      default: y = {2'b00, a} * {2'b00, b};
    endcase
    return y;
  endfunction

  assign alu_y = alu(cap_a, cap_b, cap_sel);

  assign rsp_valid   = (state == RESP);
  assign rsp_hs      = rsp_valid && rsp_ready;
  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  // ---------------------------------------------------------------------------
  // Next-state and grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    grant_0   = 1'b0;
    grant_1   = 1'b0;

    case (state)
      IDLE: begin
        // Requester 0 wins when alone, or on a tie when requester 1 owned the
        // last response; otherwise requester 1 wins if it is valid.
        if (req_valid_0 && (!req_valid_1 || last)) begin
          grant_0 = 1'b1;
        end else if (req_valid_1) begin
          grant_1 = 1'b1;
        end
        if (grant_0 || grant_1) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // No operation is accepted while reset is held, whatever the state.
    if (rst) begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, capture and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register here
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      cap_a   <= 2'd0;
      cap_b   <= 2'd0;
      cap_sel <= 2'd0;
      cap_id  <= 1'b0;
      rsp_id  <= 1'b0;
      rsp_y   <= 4'h0;
    end else begin
      state <= state_nxt;

      if (grant_0 || grant_1) begin
        cap_a   <= grant_1 ? req_a_1   : req_a_0;
        cap_b   <= grant_1 ? req_b_1   : req_b_0;
        cap_sel <= grant_1 ? req_sel_1 : req_sel_0;
        cap_id  <= grant_1;
      end

      // rsp_id / rsp_y are only loaded in EXEC, so they stay constant for
      // the whole of RESP however long the consumer stalls.
      if (state == EXEC) begin
        rsp_y  <= alu_y;
        rsp_id <= cap_id;
      end

      if (rsp_hs) begin
        last <= rsp_id;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Per-requester completion counters, wrapping at 255 -> 0
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt_0 <= 8'd0;
      stat_cnt_1 <= 8'd0;
    end else if (rsp_hs) begin
      if (rsp_id) begin
        stat_cnt_1 <= stat_cnt_1 + 8'd1;
      end else begin
        stat_cnt_0 <= stat_cnt_0 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A transaction-level model (one
// in-flight operation with its age in cycles, the owner of the last
// response, per-requester completion counts) predicts the outputs every
// cycle; directed sequences add hand-computed literal expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [1:0] a0, b0, s0, a1, b1, s1;
  logic       req_ready_0, req_ready_1;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [3:0] rsp_y;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] stat_cnt_0, stat_cnt_1;
`endif

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_0 (v0),
    .req_a_0     (a0),
    .req_b_0     (b0),
    .req_sel_0   (s0),
    .req_ready_0 (req_ready_0),
    .req_valid_1 (v1),
    .req_a_1     (a1),
    .req_b_1     (b1),
    .req_sel_1   (s1),
    .req_ready_1 (req_ready_1),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_y       (rsp_y),
    .rsp_ready   (rsp_ready)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_cnt_0  (stat_cnt_0),
    .stat_cnt_1  (stat_cnt_1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int alu_ref(input int a, input int b, input int sel);
    case (sel)
      0:       return (~a) & 3;
      1:       return (~(a & b)) & 3;
      2:       return a + b;
      default: return a * b;
    endcase
  endfunction

  bit model_on = 1'b0;
  bit m_busy   = 1'b0;
  int m_age    = 0;      // cycles since the accepting edge
  bit m_id     = 1'b0;
  int m_y      = 0;
  bit m_last   = 1'b1;
  int m_stat[2] = '{0, 0};

  always @(negedge clk) begin
    int win;
    bit exp_rv;
    win = -1;
    exp_rv = m_busy && (m_age >= 2);
    if (!rst && !m_busy) begin
      if (v0 && v1)  win = m_last ? 0 : 1;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end

    if (model_on) begin
      check("cyc_ready_0", req_ready_0, win == 0);
      check("cyc_ready_1", req_ready_1, win == 1);
      check("cyc_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check("cyc_rsp_id", rsp_id, m_id);
        check("cyc_rsp_y", rsp_y, m_y);
      end
`ifdef ALU_ARB_STATS_EN
      check("cyc_stat_0", stat_cnt_0, m_stat[0]);
      check("cyc_stat_1", stat_cnt_1, m_stat[1]);
`endif
    end

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_busy   = 1'b0;
      m_last   = 1'b1;
      m_stat   = '{0, 0};
      model_on = 1'b1;
    end else if (model_on) begin
      if (m_busy) begin
        if (m_age >= 2 && rsp_ready) begin
          m_busy         = 1'b0;
          m_last         = m_id;
          m_stat[m_id]   = (m_stat[m_id] + 1) % 256;
        end else begin
          m_age++;
        end
      end else if (win >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = (win == 1);
        m_y    = (win == 0) ? alu_ref(a0, b0, s0) : alu_ref(a1, b1, s1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v0  = 1'b0;
    v1  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns on the falling edge of the first cycle with rsp_valid high.
  task automatic wait_rsp(output logic id, output logic [3:0] y);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    check("rsp_timeout", seen, 1);
    id = rsp_id;
    y  = rsp_y;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic       id;
    logic [3:0] y;
    logic       g0, g1;
    int         n, guard;

    rst = 1'b1; rsp_ready = 1'b0;
    v0 = 1'b1; a0 = 2'd1; b0 = 2'd1; s0 = 2'd2;
    v1 = 1'b1; a1 = 2'd1; b1 = 2'd1; s1 = 2'd2;

    // Reset values, with both requesters valid during reset.
    tick();
    tick();
    @(negedge clk);
    check("rst_ready_0", req_ready_0, 0);
    check("rst_ready_1", req_ready_1, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_y", rsp_y, 0);
    tick();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    tick();

    // Single request: ADD 3+3 from requester 0.
    v0 = 1'b1; a0 = 2'd3; b0 = 2'd3; s0 = 2'd2; rsp_ready = 1'b1;
    @(negedge clk);
    check("single_ready_0", req_ready_0, 1);
    tick();
    v0 = 1'b0;
    @(negedge clk);
    check("single_exec_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 0);
    check("single_rsp_y", rsp_y, 4'b0110);
    tick();

    // Tie: both valid continuously; grants must alternate 0, 1, 0.
    do_reset();
    v0 = 1'b1; a0 = 2'd3; b0 = 2'd3; s0 = 2'd3;
    v1 = 1'b1; a1 = 2'd2; b1 = 2'd3; s1 = 2'd1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rsp(id, y);
      check("tie_rsp_id", id, (k == 1) ? 1 : 0);
      check("tie_rsp_y", y, (k == 1) ? 4'b0001 : 4'd9);
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) tick();

    // Backpressure: NOT 1 held for several cycles with rsp_ready low.
    do_reset();
    rsp_ready = 1'b0;
    v0 = 1'b1; a0 = 2'd1; b0 = 2'd0; s0 = 2'd0;
    @(negedge clk);
    check("bp_accept_0", req_ready_0, 1);
    tick();
    v0 = 1'b0;
    v1 = 1'b1; a1 = 2'd2; b1 = 2'd2; s1 = 2'd2;
    wait_rsp(id, y);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_y", rsp_y, 4'b0010);
      check("bp_ready_0", req_ready_0, 0);
      check("bp_ready_1", req_ready_1, 0);
      if (k < 4) @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    check("bp_done_valid", rsp_valid, 0);
    check("bp_next_ready_1", req_ready_1, 1);
    tick();
    v1 = 1'b0;
    repeat (4) tick();

    // Reset during EXEC discards the operation.
    do_reset();
    rsp_ready = 1'b1;
    v0 = 1'b1; a0 = 2'd2; b0 = 2'd1; s0 = 2'd2;
    @(negedge clk);
    check("mr_accept_0", req_ready_0, 1);
    tick();
    v0  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mr_rsp_valid", rsp_valid, 0);
      check("mr_rsp_id", rsp_id, 0);
      check("mr_rsp_y", rsp_y, 0);
    end
    tick();
    v0 = 1'b1; a0 = 2'd1; b0 = 2'd2; s0 = 2'd3;
    v1 = 1'b1; a1 = 2'd3; b1 = 2'd1; s1 = 2'd2;
    @(negedge clk);
    check("mr_tie_ready_0", req_ready_0, 1);
    check("mr_tie_ready_1", req_ready_1, 0);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    repeat (5) tick();

    // Randomized traffic, including occasional resets and abandoned requests.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      g0 = req_ready_0;
      g1 = req_ready_1;
      tick();
      rst = ($urandom_range(0, 63) == 0);
      if (g0 || !v0) begin
        v0 = ($urandom_range(0, 2) != 0);
        a0 = 2'($urandom_range(0, 3));
        b0 = 2'($urandom_range(0, 3));
        s0 = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 15) == 0) begin
        v0 = 1'b0;
      end
      if (g1 || !v1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = 2'($urandom_range(0, 3));
        b1 = 2'($urandom_range(0, 3));
        s1 = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 15) == 0) begin
        v1 = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    repeat (5) tick();

`ifdef ALU_ARB_STATS_EN
    // Counter wrap: 256 requester-1 operations, then 3 requester-0 ones.
    do_reset();
    rsp_ready = 1'b1;
    v1 = 1'b1; a1 = 2'd1; b1 = 2'd2; s1 = 2'd3;
    n = 0;
    guard = 0;
    while (n < 256 && guard < 2000) begin
      @(negedge clk);
      if (req_ready_1) n++;
      guard++;
      tick();
      if (n == 256) v1 = 1'b0;
    end
    v1 = 1'b0;
    check("stats_accepts_1", n, 256);
    v0 = 1'b1; a0 = 2'd2; b0 = 2'd2; s0 = 2'd2;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 100) begin
      @(negedge clk);
      if (req_ready_0) n++;
      guard++;
      tick();
      if (n == 3) v0 = 1'b0;
    end
    v0 = 1'b0;
    check("stats_accepts_0", n, 3);
    repeat (6) tick();
    @(negedge clk);
    check("stats_cnt_1", stat_cnt_1, 0);
    check("stats_cnt_0", stat_cnt_0, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
